alu_share_ctrl: RTL

- Sequencer/arbiter that shares one combinational N-bit ALU datapath between two requesters.
- Per-requester valid/ready handshakes; round-robin grant; operands and opcode registered onto the ALU port for LAT cycles; result captured into a response register.
- Response held until the consumer accepts it; overflow masked for logic ops and accumulated in a sticky flag.

---
 rtl/alu_share_ctrl_pkg.sv | 16 +
 rtl/alu_share_ctrl_rr_arb2.sv | 11 +
 rtl/alu_share_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg: opcodes, FSM encoding and opcode helper shared by the ALU sharing controller
package alu_share_ctrl_pkg;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_NOR = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;
   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction
endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// alu_share_ctrl_rr_arb2: two-way round-robin arbiter, combinational one-hot grant
// ports: req0_i/req1_i requests, ptr_i favoured requester on contention, gnt_o one-hot grant
module alu_share_ctrl_rr_arb2 (
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o
);
   assign gnt_o[0] = req0_i & (~req1_i | ~ptr_i);
   assign gnt_o[1] = req1_i & (~req0_i | ptr_i);
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one external combinational ALU between two valid/ready requesters
// ports: CLK/RSTN clock and async active-low reset; REQx_* requester handshakes and operands;
//        ALU_A/B/OP registered ALU drive, ALU_C/ALU_OV ALU result; RSP_* held response with
//        masked overflow and issuing ID; STICKY_OV accumulated overflow, CLR_OV clears it
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter int N   = 32,
   parameter int LAT = 1
) (
   input  logic         CLK,
   input  logic         RSTN,
   input  logic         REQ0_VALID,
   output logic         REQ0_READY,
   input  logic [N-1:0] REQ0_A,
   input  logic [N-1:0] REQ0_B,
   input  logic [2:0]   REQ0_OP,
   input  logic         REQ1_VALID,
   output logic         REQ1_READY,
   input  logic [N-1:0] REQ1_A,
   input  logic [N-1:0] REQ1_B,
   input  logic [2:0]   REQ1_OP,
   output logic [N-1:0] ALU_A,
   output logic [N-1:0] ALU_B,
   output logic [2:0]   ALU_OP,
   input  logic [N-1:0] ALU_C,
   input  logic         ALU_OV,
   output logic         RSP_VALID,
   input  logic         RSP_READY,
   output logic [N-1:0] RSP_C,
   output logic         RSP_OV,
   output logic         RSP_ID,
   output logic         STICKY_OV,
   input  logic         CLR_OV
);
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
   state_t       state_q;
   logic         ptr_q, id_q, rsp_valid_q, rsp_ov_q, rsp_id_q, sticky_q;
   logic [3:0]   cnt_q;
   logic [N-1:0] alu_a_q, alu_b_q, rsp_c_q;
   logic [2:0]   alu_op_q;
   logic [1:0]   gnt;
   logic         idle, hs, gnt_id, rsp_acc, sticky_d;

   alu_share_ctrl_rr_arb2 u_rr_arb2 (
      .req0_i(REQ0_VALID),
      .req1_i(REQ1_VALID),
      .ptr_i (ptr_q),
      .gnt_o (gnt)
   );

   assign idle       = (state_q == IDLE);
   assign REQ0_READY = idle & gnt[0];
   assign REQ1_READY = idle & gnt[1];
   // a grant only exists for a valid requester, so any READY is a handshake
   assign hs         = REQ0_READY | REQ1_READY;
   assign gnt_id     = gnt[1];
   assign rsp_acc    = (state_q == RESP) & RSP_READY;
   // a set in the same cycle as a clear takes priority
   assign sticky_d   = (rsp_acc & rsp_ov_q) | (sticky_q & ~CLR_OV);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         id_q        <= 1'b0;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         rsp_c_q     <= '0;
         rsp_ov_q    <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
         case (state_q)
            IDLE: if (hs) begin
               alu_a_q  <= gnt_id ? REQ1_A : REQ0_A;
               alu_b_q  <= gnt_id ? REQ1_B : REQ0_B;
               alu_op_q <= gnt_id ? REQ1_OP : REQ0_OP;
               id_q     <= gnt_id;
               ptr_q    <= ~gnt_id;
               cnt_q    <= CNT_INIT;
               state_q  <= EXEC;
            end
            EXEC: if (cnt_q == '0) begin
               rsp_c_q     <= ALU_C;
               rsp_ov_q    <= ALU_OV & is_arith(alu_op_q);
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end else begin
               cnt_q <= cnt_q - 4'd1;
            end
            RESP: if (RSP_READY) begin
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ALU_A     = alu_a_q;
   assign ALU_B     = alu_b_q;
   assign ALU_OP    = alu_op_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_C     = rsp_c_q;
   assign RSP_OV    = rsp_ov_q;
   assign RSP_ID    = rsp_id_q;
   assign STICKY_OV = sticky_q;
endmodule
